alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single execution-stage ALU (ADD/SUB/MUL, carry and zero flags) between two requesters, e.g. the integer pipe and the address/branch unit. Each requester uses a valid/ready handshake. A round-robin FSM grants the ALU to one requester, holds the operands on the ALU inputs for the op's latency (1 cycle for ADD/SUB, MUL_LAT cycles for MUL), and captures result and flags. The response is returned tagged with the requester ID.

Parameters:
MUL_LAT, 4, cycles the operands are held on the ALU for MUL before capture (legal range 1..15)
WIDTH, 32, operand/result width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
req0_valid  in  1  requester 0 has an op pending
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  4  ALU control code: 0000 ADD, 0001 SUB, 0010 MUL
req0_a  in  WIDTH  operand 1
req0_b  in  WIDTH  operand 2
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
alu_data1  out  WIDTH  to ALU data1
alu_data2  out  WIDTH  to ALU data2
alu_control  out  4  to ALU control
alu_result  in  WIDTH  from ALU (combinational)
alu_carry  in  1  from ALU
alu_zero  in  1  from ALU
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_err  out  1  op code was not ADD/SUB/MUL

Behaviour:
- Reset: state=IDLE, prio=0, cnt=0. alu_data1/alu_data2/alu_control, all rsp_* outputs and rsp_valid are 0. req*_ready=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. One op in flight at most.
- IDLE, arbitration:
  - If only one valid is high, grant that requester.
  - If both are high, grant requester `prio`.
  - reqN_ready is combinational: high only in IDLE for the granted requester, so there is at most one ready per cycle.
  - On accept (valid & ready) latch op/a/b into the ALU input regs, latch grant as id, set prio = !grant, then go to EXEC.
  - cnt loads 0 for ADD/SUB and MUL_LAT-1 for MUL.
  - An illegal op also loads cnt=0 and sets the err flag.
- Requester rules: the requester holds valid, op, a and b stable until ready. Deasserting valid before ready is allowed (the request is withdrawn). A valid that is not granted stays pending with no loss.
- EXEC:
  - alu_* regs stay stable for the whole state.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: capture alu_result/alu_carry/alu_zero into rsp_* and go to RESP.
  - For an illegal op, capture result 0, carry 0, zero 0, err 1.
- RESP: rsp_valid=1 and rsp_* stable until rsp_ready. On rsp_valid & rsp_ready go to IDLE, clearing rsp_valid the next cycle. No new grant occurs in the same cycle as the response handshake.
- Latency, accept edge to rsp_valid high: 2 cycles for ADD/SUB/illegal, MUL_LAT+1 for MUL. Minimum issue interval is 3 cycles with rsp_ready held high.
- alu_data1/alu_data2/alu_control keep their last values after an op completes; they are not cleared in IDLE.
- Width: the arbiter does no arithmetic on data. Results pass through unchanged; MUL is the low WIDTH bits as produced by the ALU.
- Reset low mid-operation (EXEC or RESP): the op is dropped, all outputs return to reset values immediately, and no response is issued after reset releases.
- rsp_ready held low: the FSM stalls in RESP indefinitely and both requesters see ready=0.

Test Plan:
- Single ADD: req0 op=0000 a=5 b=7 -> req0_ready in the accept cycle; 2 cycles later rsp_valid=1, id=0, result=12, carry=0, zero=0, err=0.
- Contention round-robin: both valid from reset with req0 SUB 9-9 and req1 ADD 1+1, rsp_ready=1 -> req0 granted first (result 0, zero=1), then req1 (result 2, id=1). With both held continuously, grants alternate 0,1,0,1.
- MUL latency: MUL_LAT=4, req1 op=0010 a=6 b=7 -> rsp_valid exactly 5 cycles after accept, result=42. alu_* stay stable for all 4 EXEC cycles.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_* unchanged, req0_ready and req1_ready stay 0, and a pending req0 is granted the cycle after rsp_ready rises and the FSM returns to IDLE.
- Illegal op: op=0111 -> rsp_err=1, result=0, latency 2.
- Async reset mid-MUL: pull reset low during EXEC cycle 2 -> rsp_valid=0 and alu_* = 0 without waiting for a clock edge. After release, no spurious response and prio=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the ALU arbiter.
// slave is the arbiter side; master is the requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] alu_data1;
  logic [WIDTH-1:0] alu_data2;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_data1, alu_data2, alu_control,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_carry, rsp_zero, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_data1, alu_data2, alu_control,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU by two requesters.
// Holds operands for the op latency and returns an id-tagged response.
module alu_arbiter #(
  parameter int MUL_LAT = 4,
  parameter int WIDTH   = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             grant;
  logic             rdy0;
  logic             rdy1;
  logic [3:0]       op_sel;
  logic             is_mul;
  logic             is_legal;

  // Arbitration: a lone requester wins, prio breaks a tie.
  always_comb begin
    grant    = bus.req1_valid & (~bus.req0_valid | prio_q);
    rdy0     = (state_q == IDLE) & bus.req0_valid & ~grant;
    rdy1     = (state_q == IDLE) & bus.req1_valid & grant;
    op_sel   = grant ? bus.req1_op : bus.req0_op;
    is_mul   = 1'b0;
    is_legal = 1'b0;
    unique case (1'b1)
      (op_sel == OP_ADD),
      (op_sel == OP_SUB): is_legal = 1'b1;
      (op_sel == OP_MUL): begin
        is_legal = 1'b1;
        is_mul   = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM next state: accept in IDLE, count in EXEC, hold in RESP.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ill_d   = ill_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ctl_d   = ctl_q;
    vld_d   = vld_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (rdy0 | rdy1) begin
          d1_d    = grant ? bus.req1_a : bus.req0_a;
          d2_d    = grant ? bus.req1_b : bus.req0_b;
          ctl_d   = op_sel;
          id_d    = grant;
          prio_d  = ~grant;
          cnt_d   = is_mul ? MUL_CNT : 4'd0;
          ill_d   = ~is_legal;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = ill_q ? '0 : bus.alu_result;
          carry_d = ~ill_q & bus.alu_carry;
          zero_d  = ~ill_q & bus.alu_zero;
          err_d   = ill_q;
          vld_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      ill_q   <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctl_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ill_q   <= ill_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ctl_q   <= ctl_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.alu_data1   = d1_q;
  assign bus.alu_data2   = d2_q;
  assign bus.alu_control = ctl_q;
  assign bus.rsp_valid   = vld_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_carry   = carry_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_err     = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random traffic for alu_arbiter.
// A transaction-level model predicts grants, latency and responses.
module tb_alu_arbiter;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(
    .MUL_LAT(MUL_LAT),
    .WIDTH  (WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic             v[2];
  logic [3:0]       op[2];
  logic [WIDTH-1:0] a[2];
  logic [WIDTH-1:0] b[2];
  logic             acc[2];
  logic             rsp_rdy;

  logic             m_busy;
  int               m_wait;
  logic             m_prio;
  logic             m_id;
  logic [3:0]       m_op;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic             m_last;

  // Bench ALU: {carry, zero, result}; junk for undefined codes.
  function automatic logic [WIDTH+1:0] alu_fn(
    input logic [3:0] f, input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     s;
    logic [WIDTH-1:0]   r;
    logic               c;
    case (f)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
      end
      4'd1: begin
        s = {1'b0, x} - {1'b0, y};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
      end
      4'd2: begin
        p = x * y;
        r = p[WIDTH-1:0];
        c = |p[2*WIDTH-1:WIDTH];
      end
      default: begin
        r = x ^ y ^ 32'h5a5a_0001;
        c = 1'b1;
      end
    endcase
    return {c, (r == '0), r};
  endfunction

  always_comb begin
    {bus.alu_carry, bus.alu_zero, bus.alu_result} =
      alu_fn(bus.alu_control, bus.alu_data1, bus.alu_data2);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    bus.req0_valid = v[0];
    bus.req0_op    = op[0];
    bus.req0_a     = a[0];
    bus.req0_b     = b[0];
    bus.req1_valid = v[1];
    bus.req1_op    = op[1];
    bus.req1_a     = a[1];
    bus.req1_b     = b[1];
    bus.rsp_ready  = rsp_rdy;
  endtask

  // One cycle: check DUT against model, then advance model.
  task automatic check_cycle();
    logic             e0, e1;
    logic [WIDTH+1:0] r;
    apply();
    #1;
    e0 = !m_busy && v[0] && (!v[1] || m_prio == 1'b0);
    e1 = !m_busy && v[1] && (!v[0] || m_prio == 1'b1);
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("rsp_valid", bus.rsp_valid, m_busy && m_wait == 0);
    if (m_busy && m_wait == 0) begin
      r = alu_fn(m_op, m_a, m_b);
      if (m_op > 4'd2) r = '0;
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_result", bus.rsp_result, r[WIDTH-1:0]);
      chk("rsp_zero", bus.rsp_zero, r[WIDTH]);
      chk("rsp_carry", bus.rsp_carry, r[WIDTH+1]);
      chk("rsp_err", bus.rsp_err, m_op > 4'd2);
    end
    if (m_last) begin
      chk("alu_data1", bus.alu_data1, m_a);
      chk("alu_data2", bus.alu_data2, m_b);
      chk("alu_control", bus.alu_control, m_op);
    end
    acc[0] = e0;
    acc[1] = e1;
    if (m_busy) begin
      if (m_wait > 0) m_wait--;
      else if (rsp_rdy) m_busy = 1'b0;
    end else if (e0 || e1) begin
      m_id   = e1;
      m_op   = op[e1];
      m_a    = a[e1];
      m_b    = b[e1];
      m_busy = 1'b1;
      m_last = 1'b1;
      m_wait = (op[e1] == 4'd2) ? MUL_LAT : 1;
      m_prio = ~e1;
    end
    @(negedge clk);
  endtask

  task automatic drop_acc();
    if (acc[0]) v[0] = 1'b0;
    if (acc[1]) v[1] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      drop_acc();
    end
  endtask

  task automatic req(input int i, input logic [3:0] f,
                     input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    v[i]  = 1'b1;
    op[i] = f;
    a[i]  = x;
    b[i]  = y;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_wait = 0;
    m_prio = 1'b0;
    m_last = 1'b0;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i]  = 1'b0;
      op[i] = '0;
      a[i]  = '0;
      b[i]  = '0;
    end
    rsp_rdy = 1'b1;
    m_id = 1'b0;
    m_op = '0;
    m_a  = '0;
    m_b  = '0;
    model_reset();
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_result", bus.rsp_result, '0);
    chk("rst_alu_control", bus.alu_control, '0);
    chk("rst_alu_data1", bus.alu_data1, '0);
    reset = 1'b1;
    @(negedge clk);

    req(0, 4'd0, 5, 7);
    run(4);

    req(0, 4'd1, 9, 9);
    req(1, 4'd0, 1, 1);
    for (int i = 0; i < 12; i++) check_cycle();
    v[0] = 1'b0;
    v[1] = 1'b0;
    run(4);

    req(1, 4'd2, 6, 7);
    run(8);

    req(0, 4'd0, 3, 4);
    check_cycle();
    drop_acc();
    check_cycle();
    rsp_rdy = 1'b0;
    req(0, 4'd0, 10, 20);
    for (int i = 0; i < 10; i++) check_cycle();
    rsp_rdy = 1'b1;
    run(6);

    req(0, 4'd7, 3, 4);
    run(4);

    req(1, 4'd2, 9, 9);
    check_cycle();
    drop_acc();
    check_cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_alu_data1", bus.alu_data1, '0);
    chk("arst_alu_data2", bus.alu_data2, '0);
    chk("arst_alu_control", bus.alu_control, '0);
    chk("arst_req1_ready", bus.req1_ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run(8);
    req(0, 4'd0, 2, 3);
    req(1, 4'd1, 8, 3);
    run(8);

    for (int c = 0; c < 3000; c++) begin
      check_cycle();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) v[i] = 1'b0;
        else if (v[i] && $urandom_range(0, 19) == 0) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          req(i, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15))
                                              : 4'($urandom_range(0, 2)),
              ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                          : WIDTH'($urandom),
              ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                          : WIDTH'($urandom));
        end
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    rsp_rdy = 1'b1;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
